fetch_unit: RTL
===============

# fetch_unit

Instruction-fetch stage sitting between the `PC` register and decode. Drives `next_pc` into `PC`, issues word requests for `current_pc` to instruction memory, and holds issued requests in a small in-order ring buffer until their data returns. Delivers `{pc, instr}` pairs to decode over a valid/ready handshake. Discards in-flight fetches on a redirect from execute.

## Interface
- `DEPTH`, 2: ring-buffer entries; power of two, ≥2.
- `clk`  in  1  rising-edge clock; the only clock.
- `reset`  in  1  synchronous, active-high.
- `current_pc`  in  32  PC register output.
- `next_pc`  out  32  value `PC` loads every cycle.
- `redirect_valid`  in  1  branch/jump/trap redirect.
- `redirect_pc`  in  32  redirect target.
- `imem_req_valid`  out  1  fetch request.
- `imem_req_ready`  in  1  memory accepts request.
- `imem_req_addr`  out  32  word address.
- `imem_resp_valid`  in  1  read data valid; in order; no backpressure.
- `imem_resp_data`  in  32  instruction word.
- `out_valid`  out  1  instruction available to decode.
- `out_ready`  in  1  decode accepts.
- `out_pc`  out  32  PC of delivered instruction.
- `out_instr`  out  32  delivered instruction.

## Operation
- Ring entry fields: `pc[31:0]`, `instr[31:0]`, `filled`.
- Pointers: `head` (oldest entry), `tail` (next allocation), `fill` (oldest unfilled entry).
- Counters: `count` (allocated entries) and `drop` (responses still owed to flushed requests). Each counter is `$clog2(DEPTH)+1` bits.
- Issue:
  - `imem_req_valid = !reset && !redirect_valid && (count + drop < DEPTH)`.
  - `imem_req_addr = {current_pc[31:2], 2'b00}`.
- On request handshake:
  - Allocate `tail` with `pc=current_pc` and `filled=0`.
  - Advance `tail`; `count++`.
- `next_pc` priority:
  - `reset` → `current_pc`.
  - `redirect_valid` → `redirect_pc`.
  - Request handshake → `current_pc + 4` (wraps modulo 2^32).
  - Otherwise → `current_pc`, which holds the PC.
- Response:
  - If `drop > 0`: discard the data; `drop--`.
  - Otherwise: write `instr` into `fill`, set `filled`, advance `fill`.
  - A response with `drop==0` and no unfilled entry is a protocol violation and is ignored.
- Output:
  - `out_valid = head.filled && !redirect_valid`.
  - `out_pc` and `out_instr` come from `head`.
  - On handshake: clear `filled`, advance `head`, `count--`.
- Redirect:
  - Clear every entry and reset all pointers.
  - `count <= 0`.
  - `drop <= drop + unfilled_count − imem_resp_valid`.
  - `out_valid` is forced to 0 in the redirect cycle.
- Issue eligibility uses registered `count`/`drop` only. A slot freed by a pop becomes usable the following cycle.

## Timing
- Reset values:
  - Outputs: `imem_req_valid=0`, `out_valid=0`, `next_pc=current_pc`.
  - State: `count=0`, `drop=0`, all pointers 0, all `filled=0`.
- Latency:
  - Request accepted in cycle N.
  - Response earliest in N+1.
  - `out_valid` earliest in N+2, because fill is registered.
- Throughput:
  - 1 instr/cycle needs DEPTH ≥ 4 with 1-cycle memory.
  - DEPTH=2 gives 2 instructions every 3 cycles.
- Simultaneous events in one cycle:
  - Issue + response + pop is legal. `count` nets +1, 0, or −1 accordingly.
  - Redirect + response: the response is consumed by the existing `drop` if `drop>0`. Otherwise it is discarded and counted against the flushed requests.
  - Redirect + `out_ready`: no delivery occurs.
- Full (`count+drop==DEPTH`): no request is issued and `next_pc=current_pc`.
- Empty: `out_valid=0`.
- Reset mid-operation clears all state. Memory must also be reset, because no `drop` accounting survives reset.

## Configuration
- `FETCH_MISALIGN_TRAP_EN` defined:
  - Adds output `out_misaligned` (1 bit).
  - If `current_pc[1:0]!=0` and there is a free slot, no memory request is made.
  - The entry is allocated with `filled=1`, `instr=32'h00000013`, and the misaligned flag set.
  - `next_pc` holds at `current_pc` until a redirect arrives.
- Not defined: the port is absent, `current_pc[1:0]` is ignored for addressing, and `next_pc` still adds 4.

## Test plan
- Reset with `current_pc=0x80000000` → `imem_req_valid=0` and `next_pc=0x80000000` during reset. First request the cycle after reset deasserts, with addr `0x80000000` and `next_pc=0x80000004`.
- DEPTH=4, 1-cycle memory returning `0x00100093`, `0x00200113`, …, `out_ready=1` → one instruction/cycle from cycle 3. PCs are `0x80000000`, `…04`, … with correct words.
- `out_ready=0`, DEPTH=2 → exactly 2 requests issued. `next_pc` then holds at `0x80000008` until a pop.
- Two requests outstanding, redirect to `0x80000100` → `drop=2`. Next two responses are discarded. The first delivered instruction has `out_pc=0x80000100`.
- Redirect in the same cycle as a response with `drop=0` and one unfilled entry → `drop=0` afterward and no stale instruction delivered.
- `FETCH_MISALIGN_TRAP_EN` with `current_pc=0x80000002` → no memory request. `out_valid` with `out_misaligned=1` and `out_instr=0x00000013`.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC sequencing, in-order request ring buffer and decode handshake.
// Optional misaligned-PC trap entries are enabled with `define FETCH_MISALIGN_TRAP_EN.
module fetch_unit #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] current_pc,
    output logic [31:0] next_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic        out_misaligned
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0]      pc_q    [DEPTH];
    logic [31:0]      instr_q [DEPTH];
    logic [DEPTH-1:0] filled_q;

    logic [PW-1:0] head_q, head_d, tail_q, tail_d, fill_q, fill_d;
    logic [CW-1:0] count_q, count_d, drop_q, drop_d, pend_q, pend_d;
    logic [CW-1:0] owed_s;
    logic [CW:0]   occ_s;
    logic          slot_free_s, req_fire_s, resp_take_s, pop_s, alloc_s;
    logic          mis_s, trap_alloc_s, trap_block_s;

    // pend_q tracks live unfilled entries, so drop accounting on redirect is a plain sum
    assign owed_s      = drop_q + pend_q;
    assign occ_s       = {1'b0, count_q} + {1'b0, drop_q};
    assign slot_free_s = (occ_s < (CW+1)'(DEPTH));

`ifdef FETCH_MISALIGN_TRAP_EN
    logic             trap_q;
    logic [DEPTH-1:0] mis_q;
    assign mis_s          = (current_pc[1:0] != 2'b00);
    assign trap_block_s   = trap_q;
    assign trap_alloc_s   = !reset && !redirect_valid && slot_free_s && mis_s && !trap_q;
    assign out_misaligned = mis_q[head_q];
`else
    assign mis_s        = 1'b0;
    assign trap_block_s = 1'b0;
    assign trap_alloc_s = 1'b0;
`endif

    assign imem_req_valid = !reset && !redirect_valid && slot_free_s && !mis_s && !trap_block_s;
    assign imem_req_addr  = {current_pc[31:2], 2'b00};
    assign req_fire_s     = imem_req_valid && imem_req_ready;
    assign alloc_s        = req_fire_s || trap_alloc_s;
    assign resp_take_s    = imem_resp_valid && !redirect_valid && (drop_q == '0) && (pend_q != '0);

    assign out_valid = filled_q[head_q] && !redirect_valid && !reset;
    assign out_pc    = pc_q[head_q];
    assign out_instr = instr_q[head_q];
    assign pop_s     = out_valid && out_ready;

    // PC sequencing
    always_comb begin
        if (reset) begin
            next_pc = current_pc;
        end else if (redirect_valid) begin
            next_pc = redirect_pc;
        end else if (req_fire_s) begin
            next_pc = current_pc + 32'd4;
        end else begin
            next_pc = current_pc;
        end
    end

    // Pointer and counter next state
    always_comb begin
        count_d = count_q;
        drop_d  = drop_q;
        pend_d  = pend_q;
        head_d  = head_q;
        tail_d  = tail_q;
        fill_d  = fill_q;
        if (redirect_valid) begin
            count_d = '0;
            pend_d  = '0;
            head_d  = '0;
            tail_d  = '0;
            fill_d  = '0;
            if (imem_resp_valid && (owed_s != '0)) begin
                drop_d = owed_s - CW'(1);
            end else begin
                drop_d = owed_s;
            end
        end else begin
            count_d = count_q + CW'(alloc_s) - CW'(pop_s);
            pend_d  = pend_q + CW'(req_fire_s) - CW'(resp_take_s);
            tail_d  = tail_q + PW'(alloc_s);
            head_d  = head_q + PW'(pop_s);
            fill_d  = fill_q + PW'(resp_take_s);
            if (imem_resp_valid && (drop_q != '0)) begin
                drop_d = drop_q - CW'(1);
            end else begin
                drop_d = drop_q;
            end
        end
    end

    // Control state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            drop_q  <= '0;
            pend_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            fill_q  <= '0;
        end else begin
            count_q <= count_d;
            drop_q  <= drop_d;
            pend_q  <= pend_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            fill_q  <= fill_d;
        end
    end

    // Ring entry storage
    always_ff @(posedge clk) begin
        if (reset) begin
            filled_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]    <= 32'd0;
                instr_q[i] <= 32'd0;
            end
        end else if (redirect_valid) begin
            filled_q <= '0;
        end else begin
            if (alloc_s) begin
                pc_q[tail_q]     <= current_pc;
                instr_q[tail_q]  <= trap_alloc_s ? NOP : 32'd0;
                filled_q[tail_q] <= trap_alloc_s;
            end
            if (resp_take_s) begin
                instr_q[fill_q]  <= imem_resp_data;
                filled_q[fill_q] <= 1'b1;
            end
            if (pop_s) begin
                filled_q[head_q] <= 1'b0;
            end
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    // Trap bookkeeping: one trap entry per misaligned PC until redirected
    always_ff @(posedge clk) begin
        if (reset) begin
            trap_q <= 1'b0;
            mis_q  <= '0;
        end else if (redirect_valid) begin
            trap_q <= 1'b0;
            mis_q  <= '0;
        end else begin
            if (trap_alloc_s) begin
                trap_q <= 1'b1;
            end
            if (alloc_s) begin
                mis_q[tail_q] <= trap_alloc_s;
            end
        end
    end
`endif

endmodule
